// File: rtl/check_guess.sv
// Game judge: captures a secret digit, compares committed guesses, shows hint/result and times the result display.
// Compare lands one cycle after buttonSel; every output is registered; no backpressure, inputs are one-cycle strobes.
module check_guess #(
    parameter int MAX_TRIES     = 3,
    parameter int DIGIT_MAX     = 9,
    parameter int RESULT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       buttonStart,
    input  logic       buttonSel,
    input  logic [4:0] userguess,
    output logic [1:0] state,
    output logic [7:0] HEX1g,
    output logic       winLED,
    output logic       loseLED,
    output logic [4:0] secret
);
    typedef enum logic [1:0] {
        SETUP = 2'b00,
        GUESS = 2'b01,
        WIN   = 2'b10,
        LOSE  = 2'b11
    } state_t;

    localparam int             TW         = $clog2(RESULT_CYCLES + 1);
    localparam logic [4:0]     RND_MAX    = 5'(DIGIT_MAX);
    localparam logic [1:0]     TRIES_INIT = 2'(MAX_TRIES);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(RESULT_CYCLES - 1);

    state_t          st;
    logic [4:0]      rnd;
    logic [1:0]      tries_left;
    logic            pend;
    logic [TW-1:0]   timer;

    function automatic logic [7:0] seg(input logic [4:0] d);
        case (d)
            5'd0:    seg = 8'hC0;
            5'd1:    seg = 8'hF9;
            5'd2:    seg = 8'hA4;
            5'd3:    seg = 8'hB0;
            5'd4:    seg = 8'h99;
            5'd5:    seg = 8'h92;
            5'd6:    seg = 8'h82;
            5'd7:    seg = 8'hF8;
            5'd8:    seg = 8'h80;
            5'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
    endfunction

    assign state = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= SETUP;
            secret     <= 5'd0;
            rnd        <= 5'd0;
            tries_left <= TRIES_INIT;
            pend       <= 1'b0;
            timer      <= '0;
            HEX1g      <= 8'hFF;
            winLED     <= 1'b0;
            loseLED    <= 1'b0;
        end else begin
            rnd  <= (rnd >= RND_MAX) ? 5'd0 : rnd + 5'd1;
            // One-cycle delay lets guess entry register userguess on the same strobe.
            pend <= (st == GUESS) && buttonSel;

            unique case (st)
                SETUP: begin
                    if (buttonStart) begin
                        secret     <= rnd;
                        tries_left <= TRIES_INIT;
                        HEX1g      <= 8'hFF;
                        timer      <= '0;
                        st         <= GUESS;
                    end
                end
                GUESS: begin
                    if (pend) begin
                        if (userguess == secret) begin
                            st     <= WIN;
                            winLED <= 1'b1;
                            HEX1g  <= seg(secret);
                            timer  <= '0;
                        end else if (tries_left == 2'd1) begin
                            st      <= LOSE;
                            loseLED <= 1'b1;
                            HEX1g   <= seg(secret);
                            timer   <= '0;
                        end else begin
                            tries_left <= tries_left - 2'd1;
                            HEX1g      <= (userguess > secret) ? 8'h89 : 8'hC7;
                        end
                    end
                end
                WIN, LOSE: begin
                    if (timer == TIMER_LAST) begin
                        st      <= SETUP;
                        HEX1g   <= 8'hFF;
                        winLED  <= 1'b0;
                        loseLED <= 1'b0;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/check_guess.md
Name: check_guess

Overview:
- Judge end of the number-guessing game; counterpart to the guess-entry block.
- Owns the game state bus that guess entry consumes (00 setup, 01 guessing, 10 win, 11 lose).
- Captures a pseudo-random secret digit, compares each committed guess against it, and drives a hint/result seven-segment display and win/lose LEDs.
- Returns to setup automatically after a timed result display.

Parameters:
- MAX_TRIES, 3: guesses allowed per round (1..3).
- DIGIT_MAX, 9: largest secret value; secret range is 0..DIGIT_MAX.
- RESULT_CYCLES, 50000000: clock cycles the WIN/LOSE result is held before returning to setup.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- buttonStart  in  1  one-cycle pulse; starts a round.
- buttonSel  in  1  one-cycle pulse, the same strobe the guess-entry block uses to commit userguess.
- userguess  in  5  committed guess from guess entry; valid on the cycle after buttonSel.
- state  out  2  game state: 00 SETUP, 01 GUESS, 10 WIN, 11 LOSE.
- HEX1g  out  8  active-low segments: bit0=a … bit6=g, bit7=dp.
- winLED  out  1  high in WIN.
- loseLED  out  1  high in LOSE.
- secret  out  5  current secret, for the bench and debug.

Behaviour:
- Reset (async, any state, mid-round included):
  - state=00, secret=0, rnd=0, tries_left=MAX_TRIES, pend=0, timer=0.
  - HEX1g=8'hFF (blank), winLED=0, loseLED=0.
- rnd counter:
  - Free-running, increments every cycle in every state.
  - Wraps from DIGIT_MAX to 0.
- pend register:
  - pend <= buttonSel every cycle in GUESS; cleared in every other state.
  - This gives the guess-entry block one cycle to register userguess.
- SETUP (00):
  - On buttonStart: secret <= rnd (value before the edge), tries_left <= MAX_TRIES, HEX1g blank, go to GUESS.
  - buttonSel ignored.
- GUESS (01): when pend=1, compare userguess to secret as 5-bit unsigned.
  - Equal: go to WIN; winLED=1; HEX1g = secret digit pattern.
  - Not equal, tries_left==1: go to LOSE; loseLED=1; HEX1g = secret digit pattern.
  - Not equal, tries_left>1: tries_left--; stay in GUESS.
    - HEX1g=8'h89 ('H') if userguess>secret.
    - HEX1g=8'hC7 ('L') if userguess<secret.
  - userguess=5'b11111 (no-guess sentinel) compares as greater, giving 'H'.
  - buttonStart ignored in GUESS.
- Latency:
  - buttonSel high at edge N; compare at edge N+1.
  - state, HEX1g and LEDs show the result after edge N+1.
- Back-to-back presses: buttonSel high on the compare cycle sets pend again, and the next compare happens one cycle later. No guess is lost.
- WIN (10) / LOSE (11):
  - timer counts from 0 on entry.
  - At timer==RESULT_CYCLES-1: go to SETUP, HEX1g=8'hFF, LEDs=0, timer=0.
  - buttonStart and buttonSel ignored.
- Digit patterns, active-low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Any other secret value: FF.
- Outputs are registered only; no combinational path from any input to any output.

Test Plan:
- Reset/start: assert rst mid-GUESS → state=00, HEX1g=FF, LEDs=0 immediately. Release rst, buttonStart at the cycle where rnd=6 → secret=6, state=01.
- Hints: secret=6, userguess=8 with buttonSel → 2 edges later HEX1g=89, state=01, tries_left=2. Then userguess=2 → HEX1g=C7, tries_left=1.
- Win: secret=6, userguess=6 → state=10, winLED=1, HEX1g=82. After RESULT_CYCLES=8 cycles (sim override) → state=00, HEX1g=FF, winLED=0.
- Lose: secret=4, guesses 1, 7, 9 → third compare gives state=11, loseLED=1, HEX1g=99. 8 cycles later → state=00.
- Back-to-back: buttonSel on two consecutive cycles with userguess 3 then 5, secret=4 → HEX1g=C7 then 89 on consecutive cycles, tries_left=1.
- Ignored inputs: buttonSel in SETUP and buttonStart in GUESS/WIN → no state change. rnd wraps 9→0 without ever reaching 10.
